// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency ROM and hands
// instructions to decode through an output register backed by a one-entry skid buffer.
module fetch_unit #(
   parameter int                ADDR_W   = 16,
   parameter int                INSTR_W  = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                PC_STEP  = 1
) (
   input  logic               clk,
   input  logic               reset,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [INSTR_W-1:0] rom_q,
   input  logic               stall,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_addr,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid
);

   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic               inflight_q, inflight_d;
   logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
   logic               out_valid_q, out_valid_d;
   logic [INSTR_W-1:0] out_instr_q, out_instr_d;
   logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
   logic               skid_valid_q, skid_valid_d;
   logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
   logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;

   logic consume;
   logic issue_en;

   assign consume  = out_valid_q && !stall;
   // Stop issuing once the returning word would be the last one the skid can absorb.
   assign issue_en = !skid_valid_q && !(stall && out_valid_q && inflight_q);

   always_comb begin
      pc_d          = pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      out_valid_d   = out_valid_q;
      out_instr_d   = out_instr_q;
      out_pc_d      = out_pc_q;
      skid_valid_d  = skid_valid_q;
      skid_instr_d  = skid_instr_q;
      skid_pc_d     = skid_pc_q;

      if (redirect_valid) begin
         pc_d         = redirect_addr;
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else begin
         if (issue_en) begin
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
            pc_d          = pc_q + ADDR_W'(PC_STEP);
         end

         if (consume && skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_instr_d  = skid_instr_q;
            out_pc_d     = skid_pc_q;
            skid_valid_d = inflight_q;
            if (inflight_q) begin
               skid_instr_d = rom_q;
               skid_pc_d    = inflight_pc_q;
            end
         end else if (inflight_q && (!out_valid_q || consume) && !skid_valid_q) begin
            out_valid_d = 1'b1;
            out_instr_d = rom_q;
            out_pc_d    = inflight_pc_q;
         end else if (inflight_q) begin
            skid_valid_d = 1'b1;
            skid_instr_d = rom_q;
            skid_pc_d    = inflight_pc_q;
         end else if (consume) begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         out_valid_q   <= 1'b0;
         out_instr_q   <= '0;
         out_pc_q      <= '0;
         skid_valid_q  <= 1'b0;
         skid_instr_q  <= '0;
         skid_pc_q     <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         out_valid_q   <= out_valid_d;
         out_instr_q   <= out_instr_d;
         out_pc_q      <= out_pc_d;
         skid_valid_q  <= skid_valid_d;
         skid_instr_q  <= skid_instr_d;
         skid_pc_q     <= skid_pc_d;
      end
   end

   assign rom_addr    = pc_q;
   assign instr_out   = out_instr_q;
   assign instr_pc    = out_pc_q;
   assign instr_valid = out_valid_q;

endmodule
